puf_codeword_assembler: RTL and testbench

Front-end stage feeding the BCH decoder wrapper (`bch_wrapper_decoder`) during PUF key regeneration.
- Serially collects `DATA_BITS` fresh PUF response bits.
- Fetches the stored ECC helper bits from external byte-wide memory.
- Assembles the noisy codeword `{data, ecc}` and launches one decode with a start/ready handshake.
- Signals completion to the key-generation controller.

---
 rtl/puf_codeword_assembler_pkg.sv | 30 +++
 rtl/puf_ecc_fetch.sv | 84 ++++++++
 rtl/puf_codeword_assembler.sv | 134 +++++++++++++
 tb/tb_puf_codeword_assembler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/puf_codeword_assembler_pkg.sv
// -----------------------------------------------------------------------------
// puf_codeword_assembler_pkg
// Shared definitions for the PUF codeword assembler:
//   - FSM state encoding (3-bit legacy-compatible constants)
//   - ceil_div(): byte count needed to hold the ECC field
//   - idx_w():    safe index width for a count (never 0 bits)
//   - code_bits(): codeword width {data, ecc}, also usable by decoder benches
// -----------------------------------------------------------------------------
package puf_codeword_assembler_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_LAUNCH  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int code_bits(input int data_bits, input int ecc_bits);
    return data_bits + ecc_bits;
  endfunction

endpackage

// File: rtl/puf_ecc_fetch.sv
// -----------------------------------------------------------------------------
// puf_ecc_fetch
// Reads ceil(ECC_BITS/MEM_DA_B) helper bytes from a byte-wide memory with a
// one-cycle read latency and packs them LSB-first into o_ecc. Bits of the
// last byte beyond ECC_BITS are dropped.
// Ports:
//   i_clk, i_rst_n   clock / async active-low reset
//   i_go             one-cycle request, sampled at the edge that starts reads
//   i_base           address of the first ECC byte
//   o_rd, o_addr     memory read strobe / address
//   i_data           read data, valid the cycle after o_rd
//   o_ecc            assembled ECC vector (held until the next fetch)
//   o_done           high in the cycle the last byte is on i_data
// -----------------------------------------------------------------------------
module puf_ecc_fetch
  import puf_codeword_assembler_pkg::*;
#(
  parameter int ECC_BITS = 10,
  parameter int MEM_AD_B = 5,
  parameter int MEM_DA_B = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_go,
  input  logic [MEM_AD_B-1:0] i_base,
  output logic                o_rd,
  output logic [MEM_AD_B-1:0] o_addr,
  input  logic [MEM_DA_B-1:0] i_data,
  output logic [ECC_BITS-1:0] o_ecc,
  output logic                o_done
);

  localparam int NB = ceil_div(ECC_BITS, MEM_DA_B);
  localparam int IW = idx_w(NB);

  logic                r_rd;
  logic [MEM_AD_B-1:0] r_addr;
  logic [IW-1:0]       r_idx;   // index of the byte being requested
  logic                r_pend;  // data for byte r_pidx arrives this cycle
  logic [IW-1:0]       r_pidx;
  logic [ECC_BITS-1:0] r_ecc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd   <= 1'b0;
      r_addr <= '0;
      r_idx  <= '0;
      r_pend <= 1'b0;
      r_pidx <= '0;
      r_ecc  <= '0;
    end else begin
      r_pend <= 1'b0;
      if (i_go) begin
        r_rd   <= 1'b1;
        r_addr <= i_base;
        r_idx  <= '0;
      end else if (r_rd) begin
        r_pend <= 1'b1;
        r_pidx <= r_idx;
        if (r_idx == IW'(NB - 1)) begin
          r_rd   <= 1'b0;
          r_addr <= '0;
        end else begin
          r_idx  <= r_idx + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end
      // Per-bit write: only bits that belong to the returning byte update,
      // which discards the unused top bits of the final byte for free.
      if (r_pend) begin
        for (int i = 0; i < ECC_BITS; i++) begin
          if (r_pidx == IW'(i / MEM_DA_B))
            r_ecc[i] <= i_data[i % MEM_DA_B];
        end
      end
    end
  end

  assign o_rd   = r_rd;
  assign o_addr = r_addr;
  assign o_ecc  = r_ecc;
  assign o_done = r_pend && (r_pidx == IW'(NB - 1));

endmodule

// File: rtl/puf_codeword_assembler.sv
// -----------------------------------------------------------------------------
// puf_codeword_assembler
// Collects DATA_BITS PUF response bits, fetches the stored ECC helper bytes,
// presents {data, ecc} to the BCH decoder and runs the start/ready handshake.
// Optional watchdog: define PUF_ASM_TIMEOUT_EN to abort LAUNCH/WAIT after
// TIMEOUT cycles with a one-cycle O_err pulse.
// Ports:
//   I_clk, I_rst_n            clock / async active-low reset
//   I_start                   begin request (IDLE only)
//   I_resp_bit, I_resp_valid  serial PUF response, MSB of data first
//   O_mem_rd, O_mem_addr      helper memory read port
//   I_mem_data                read data, one cycle after O_mem_rd
//   O_code                    codeword to decoder; stable LAUNCH..next COLLECT
//   O_dec_start, I_dec_ready  decoder handshake
//   O_busy, O_done, O_err     status
// -----------------------------------------------------------------------------
module puf_codeword_assembler
  import puf_codeword_assembler_pkg::*;
#(
  parameter int DATA_BITS = 5,
  parameter int ECC_BITS  = 10,
  parameter int MEM_AD_B  = 5,
  parameter int MEM_DA_B  = 8,
  parameter int ECC_BASE  = 0,
  parameter int TIMEOUT   = 255,
  localparam int CODE_BITS = code_bits(DATA_BITS, ECC_BITS)
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_start,
  input  logic                 I_resp_bit,
  input  logic                 I_resp_valid,
  output logic                 O_mem_rd,
  output logic [MEM_AD_B-1:0]  O_mem_addr,
  input  logic [MEM_DA_B-1:0]  I_mem_data,
  output logic [CODE_BITS-1:0] O_code,
  output logic                 O_dec_start,
  input  logic                 I_dec_ready,
  output logic                 O_busy,
  output logic                 O_done,
  output logic                 O_err
);

  localparam int CW = $clog2(DATA_BITS + 1);

  if (TIMEOUT < 1) begin : g_cfg_check
    $error("puf_codeword_assembler: TIMEOUT must be >= 1");
  end

  logic [2:0]           r_state;
  logic [2:0]           w_nxt;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic                 w_go;
  logic                 w_fdone;
  logic                 w_to;
  logic [ECC_BITS-1:0]  w_ecc;

  puf_ecc_fetch #(
    .ECC_BITS (ECC_BITS),
    .MEM_AD_B (MEM_AD_B),
    .MEM_DA_B (MEM_DA_B)
  ) u_fetch (
    .i_clk   (I_clk),
    .i_rst_n (I_rst_n),
    .i_go    (w_go),
    .i_base  (MEM_AD_B'(ECC_BASE)),
    .o_rd    (O_mem_rd),
    .o_addr  (O_mem_addr),
    .i_data  (I_mem_data),
    .o_ecc   (w_ecc),
    .o_done  (w_fdone)
  );

`ifdef PUF_ASM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;
  logic          w_wd_run;

  assign w_wd_run = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign w_to     = w_wd_run && (r_wd == WW'(TIMEOUT));

  // Cleared on every state change so LAUNCH and WAIT each get a full budget.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)              r_wd <= '0;
    else if (w_nxt != r_state) r_wd <= '0;
    else if (w_wd_run)         r_wd <= r_wd + 1'b1;
  end
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    w_go  = 1'b0;
    case (r_state)
      S_IDLE:    if (I_start) w_nxt = S_COLLECT;
      S_COLLECT: if (I_resp_valid && (r_cnt == CW'(DATA_BITS - 1))) begin
                   w_nxt = S_FETCH;
                   w_go  = 1'b1;
                 end
      S_FETCH:   if (w_fdone) w_nxt = S_LAUNCH;
      S_LAUNCH:  if (!I_dec_ready) w_nxt = S_WAIT;
      S_WAIT:    if (I_dec_ready) w_nxt = S_DONE;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    if (w_to) w_nxt = S_IDLE;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && I_start) begin
        r_cnt <= '0;
      end else if (r_state == S_COLLECT && I_resp_valid) begin
        r_data <= {r_data[DATA_BITS-2:0], I_resp_bit};
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign O_code      = {r_data, w_ecc};
  // Start is withdrawn combinationally the first cycle ready is seen low.
  assign O_dec_start = (r_state == S_LAUNCH) && I_dec_ready && !w_to;
  assign O_busy      = (r_state != S_IDLE);
  assign O_done      = (r_state == S_DONE);
  assign O_err       = w_to;

endmodule

// File: tb/tb_puf_codeword_assembler.sv
// -----------------------------------------------------------------------------
// tb_puf_codeword_assembler
// Directed bench for puf_codeword_assembler: nominal assembly, handshake,
// ignored inputs, reset mid-fetch, upper-bit masking and (with
// PUF_ASM_TIMEOUT_EN) the watchdog.
// -----------------------------------------------------------------------------
module tb_puf_codeword_assembler;

  logic        I_clk;
  logic        I_rst_n;
  logic        I_start;
  logic        I_resp_bit;
  logic        I_resp_valid;
  logic        O_mem_rd;
  logic [4:0]  O_mem_addr;
  logic [7:0]  I_mem_data;
  logic [14:0] O_code;
  logic        O_dec_start;
  logic        I_dec_ready;
  logic        O_busy;
  logic        O_done;
  logic        O_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:31];

  puf_codeword_assembler #(
    .DATA_BITS (5),
    .ECC_BITS  (10),
    .MEM_AD_B  (5),
    .MEM_DA_B  (8),
    .ECC_BASE  (0),
    .TIMEOUT   (16)
  ) dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_start      (I_start),
    .I_resp_bit   (I_resp_bit),
    .I_resp_valid (I_resp_valid),
    .O_mem_rd     (O_mem_rd),
    .O_mem_addr   (O_mem_addr),
    .I_mem_data   (I_mem_data),
    .O_code       (O_code),
    .O_dec_start  (O_dec_start),
    .I_dec_ready  (I_dec_ready),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_err        (O_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Byte memory with one-cycle read latency.
  always @(posedge I_clk)
    if (O_mem_rd) I_mem_data <= mem[O_mem_addr];

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
  endtask

  // Start + 5 response bits (MSB first). The start cycle also carries a
  // valid bit that must not be captured. Returns in FETCH cycle 1.
  task automatic run_collect(input logic [4:0] bits, input bit gap);
    I_start = 1'b1; I_resp_valid = 1'b1; I_resp_bit = 1'b1;
    tick();
    I_start = 1'b0; I_resp_valid = 1'b0;
    check("busy_collect", 32'(O_busy), 32'd1);
    for (int i = 4; i >= 0; i--) begin
      I_resp_valid = 1'b1; I_resp_bit = bits[i];
      tick();
      I_resp_valid = 1'b0;
      if (gap && i != 0) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hA5; mem[1] = 8'h03;
    I_mem_data = 8'h00;
    I_rst_n = 1'b0; I_start = 1'b0; I_resp_bit = 1'b0; I_resp_valid = 1'b0;
    I_dec_ready = 1'b1;
    tick(); tick();
    check("rst_code",  32'(O_code),      32'h0);
    check("rst_rd",    32'(O_mem_rd),    32'h0);
    check("rst_addr",  32'(O_mem_addr),  32'h0);
    check("rst_start", 32'(O_dec_start), 32'h0);
    check("rst_busy",  32'(O_busy),      32'h0);
    check("rst_done",  32'(O_done),      32'h0);
    check("rst_err",   32'(O_err),       32'h0);
    I_rst_n = 1'b1;
    tick();

    // Nominal with gaps; start pulse in FETCH must be ignored.
    run_collect(5'b10110, 1'b1);
    check("fetch_rd0",   32'(O_mem_rd),   32'd1);
    check("fetch_addr0", 32'(O_mem_addr), 32'd0);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    check("fetch_rd1",   32'(O_mem_rd),   32'd1);
    check("fetch_addr1", 32'(O_mem_addr), 32'd1);
    tick();
    check("fetch_rd_off",  32'(O_mem_rd),    32'd0);
    check("start_not_e3",  32'(O_dec_start), 32'd0);
    tick();
    check("start_e4",  32'(O_dec_start), 32'd1);
    check("code_nom",  32'(O_code),      32'h5BA5);

    // Handshake: start held 3 cycles, ready drops in the 4th.
    tick();
    check("start_l2", 32'(O_dec_start), 32'd1);
    tick();
    check("start_l3", 32'(O_dec_start), 32'd1);
    tick();
    I_dec_ready = 1'b0;
    #1;
    check("start_drop", 32'(O_dec_start), 32'd0);
    tick();
    I_resp_valid = 1'b1; I_resp_bit = 1'b0; I_start = 1'b1;
    repeat (19) tick();
    check("wait_code", 32'(O_code), 32'h5BA5);
    check("wait_busy", 32'(O_busy), 32'd1);
    check("wait_done", 32'(O_done), 32'd0);
    I_resp_valid = 1'b0; I_start = 1'b0; I_dec_ready = 1'b1;
    #1;
    check("done_not_yet", 32'(O_done), 32'd0);
    tick();
    check("done_pulse", 32'(O_done), 32'd1);
    tick();
    check("done_clear", 32'(O_done), 32'd0);
    check("idle_busy",  32'(O_busy), 32'd0);
    check("idle_code",  32'(O_code), 32'h5BA5);

    // Reset mid-FETCH, then a fresh run with masked upper byte bits.
    mem[1] = 8'hFF;
    run_collect(5'b01001, 1'b0);
    check("prerst_rd", 32'(O_mem_rd), 32'd1);
    I_rst_n = 1'b0;
    #1;
    check("mrst_rd",    32'(O_mem_rd),    32'd0);
    check("mrst_addr",  32'(O_mem_addr),  32'd0);
    check("mrst_code",  32'(O_code),      32'd0);
    check("mrst_busy",  32'(O_busy),      32'd0);
    check("mrst_start", 32'(O_dec_start), 32'd0);
    tick(); tick();
    I_rst_n = 1'b1;
    tick();
    run_collect(5'b01001, 1'b0);
    tick(); tick(); tick();
    check("mask_start", 32'(O_dec_start), 32'd1);
    check("mask_hi",    32'(O_code[9:8]), 32'h3);
    check("mask_code",  32'(O_code),      32'h27A5);
    tick();
    I_dec_ready = 1'b0;
    tick();
    I_dec_ready = 1'b1;
    tick();
    check("mask_done", 32'(O_done), 32'd1);
    tick();
    check("mask_idle", 32'(O_busy), 32'd0);

`ifdef PUF_ASM_TIMEOUT_EN
    // Watchdog: ready never drops.
    mem[1] = 8'h03;
    run_collect(5'b11111, 1'b0);
    tick(); tick(); tick();
    for (int k = 0; k < 16; k++) begin
      check("wd_err_low", 32'(O_err),       32'd0);
      check("wd_start",   32'(O_dec_start), 32'd1);
      tick();
    end
    check("wd_err",       32'(O_err),       32'd1);
    check("wd_start_off", 32'(O_dec_start), 32'd0);
    check("wd_no_done",   32'(O_done),      32'd0);
    tick();
    check("wd_idle",     32'(O_busy), 32'd0);
    check("wd_err_clr",  32'(O_err),  32'd0);
    check("wd_no_done2", 32'(O_done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
